// File: rtl/matrix_cfg_loader.sv
// matrix_cfg_loader: loads a switch-matrix configuration over a valid/ready
// stream into a shadow buffer. The buffer is committed to cfg_bus only after
// a checksum word matches the running XOR and every word is legal.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   cfg_start        pulse: begin or restart a load
//   cfg_valid        cfg_data holds a word this cycle
//   cfg_data [CW]    config word {index[5:3], side[2:0]} or checksum word
//   cfg_ready        loader accepts a word this cycle (LOAD/CHK)
//   cfg_busy         load in progress
//   cfg_done         one-cycle pulse on successful commit
//   cfg_err          sticky: last load was rejected
//   cfg_bus [NW*CW]  active configuration, word k at [CW*k +: CW]
module matrix_cfg_loader #(
  parameter int unsigned NTB = 5,
  parameter int unsigned NLR = 4,
  parameter int unsigned CW  = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic                             cfg_valid,
  input  logic [CW-1:0]                    cfg_data,
  output logic                             cfg_ready,
  output logic                             cfg_busy,
  output logic                             cfg_done,
  output logic                             cfg_err,
  output logic [(2*NTB+2*NLR)*CW-1:0]      cfg_bus
);

  localparam int unsigned NW    = 2 * NTB + 2 * NLR;
  localparam int unsigned BUS_W = NW * CW;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned IDX_W = CW - 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [CW-1:0]             xor_q, xor_d;
  logic                      lerr_q, lerr_d;
  logic [NW-1:0][CW-1:0]     shadow_q, shadow_d;
  logic [BUS_W-1:0]          bus_q, bus_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;

  logic [2:0]                side_c;
  logic [IDX_W-1:0]          idx_c;
  logic                      legal_c;
  logic                      hs_c;

  // Legality of the incoming word: side selects which index range applies.
  always_comb begin
    side_c  = cfg_data[2:0];
    idx_c   = cfg_data[CW-1:3];
    legal_c = 1'b0;
    case (side_c)
      3'd0:       legal_c = 1'b1;
      3'd1, 3'd3: legal_c = (32'(idx_c) < NTB);
      3'd2, 3'd4: legal_c = (32'(idx_c) < NLR);
      default:    legal_c = 1'b0;
    endcase
  end

  assign hs_c = cfg_valid && (state_q != IDLE);

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      xor_q    <= '0;
      lerr_q   <= 1'b0;
      shadow_q <= '0;
      bus_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      xor_q    <= xor_d;
      lerr_q   <= lerr_d;
      shadow_q <= shadow_d;
      bus_q    <= bus_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and datapath updates; cfg_start in any state (re)starts a load
  // and takes priority over a word handshaked in the same cycle.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    xor_d    = xor_q;
    lerr_d   = lerr_q;
    shadow_d = shadow_q;
    bus_d    = bus_q;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          count_d = '0;
          xor_d   = '0;
          lerr_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          count_d = '0;
          xor_d   = '0;
          lerr_d  = 1'b0;
        end else if (hs_c) begin
          shadow_d[count_q] = cfg_data;
          xor_d             = xor_q ^ cfg_data;
          if (!legal_c) lerr_d = 1'b1;
          // Counter holds at the last word index while the checksum is awaited.
          if (count_q == CNT_W'(NW - 1)) begin
            state_d = CHK;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      CHK: begin
        if (cfg_start) begin
          state_d = LOAD;
          count_d = '0;
          xor_d   = '0;
          lerr_d  = 1'b0;
        end else if (hs_c) begin
          state_d = IDLE;
          if ((cfg_data == xor_q) && !lerr_q) begin
            bus_d  = shadow_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_d = (state_d != IDLE);
  assign busy_d  = (state_d != IDLE);

  assign cfg_ready = ready_q;
  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign cfg_bus   = bus_q;

endmodule

// File: doc/matrix_cfg_loader.md
MATRIX_CFG_LOADER -- requirements
Module: matrix_cfg_loader

Interface
REQ-001 The block SHALL have parameter NTB, default 5, meaning the number of top ports and the number of bottom ports of the downstream switch matrix.
REQ-002 The block SHALL have parameter NLR, default 4, meaning the number of left ports and the number of right ports.
REQ-003 The block SHALL have parameter CW, default 6, meaning the config word width: bits [5:3] are the source index, bits [2:0] are the source side.
REQ-004 clk  input  1  Single clock; all state changes on its rising edge.
REQ-005 rst  input  1  Asynchronous, active-high reset.
REQ-006 cfg_start  input  1  Single-cycle pulse that begins or restarts a load.
REQ-007 cfg_valid  input  1  The word on cfg_data is valid this cycle.
REQ-008 cfg_data  input  6  Config word or checksum word.
REQ-009 cfg_ready  output  1  The loader accepts a word this cycle.
REQ-010 cfg_busy  output  1  A load is in progress.
REQ-011 cfg_done  output  1  One-cycle pulse marking a successful commit.
REQ-012 cfg_err  output  1  Sticky flag: the last load was rejected.
REQ-013 cfg_bus  output  108  Active configuration for the switch matrix; word k occupies bits [6k+5:6k].

Function
REQ-014 Word order SHALL be: k=0..4 top[k], k=5..9 bottom[k-5], k=10..13 left[k-10], k=14..17 right[k-14], then one checksum word.
REQ-015 A word SHALL transfer only in a cycle where cfg_valid and cfg_ready are both 1 (handshake).
REQ-016 The FSM SHALL have exactly three states: IDLE, LOAD, CHK.
REQ-017 IDLE -> LOAD on cfg_start; in that transition the word counter and the running XOR SHALL clear to 0 and cfg_err SHALL clear.
REQ-018 In LOAD, each handshake SHALL do all of the following:
- write cfg_data into shadow word [count];
- XOR cfg_data into the running checksum;
- increment count.
REQ-019 The handshake at count=17 SHALL move the FSM to CHK.
REQ-020 In CHK, one handshake SHALL compare cfg_data with the running XOR.
- Match with no legality error: cfg_bus loads the full shadow on the next clock edge, cfg_done pulses high for exactly that cycle, and the FSM returns to IDLE.
- Any mismatch or legality error: cfg_bus is unchanged, cfg_err sets to 1, and the FSM returns to IDLE.
REQ-021 A word SHALL be legal when:
- side [2:0] is in 0..4;
- if side is 1 or 3 (top/bottom), index [5:3] is < 5;
- if side is 2 or 4 (right/left), index [5:3] is < 4;
- if side is 0, the index is don't-care.
REQ-022 An illegal word in LOAD SHALL set an internal error bit; the load SHALL continue to CHK and then be rejected there.
REQ-023 cfg_ready SHALL be 1 in LOAD and CHK and 0 in IDLE.
REQ-024 cfg_busy SHALL be 1 in LOAD and CHK.
REQ-025 cfg_start in LOAD or CHK SHALL restart the load from count 0. The shadow SHALL be kept but overwritten by the new load, and any word handshaked in the same cycle SHALL be discarded.
REQ-026 cfg_start and a CHK handshake in the same cycle: cfg_start SHALL win, with no commit and no error.
REQ-027 cfg_bus SHALL change only on a successful commit; partial loads SHALL never be visible on it.
REQ-028 The block SHALL impose no timeout; cfg_valid may stay low for any number of cycles in LOAD or CHK without any effect.
REQ-029 The word counter SHALL be 5 bits wide and SHALL never exceed 17.

Reset
REQ-030 When rst=1, the block SHALL asynchronously force all of the following; the shadow SHALL be cleared to 0:

| Item | Reset value |
|---|---|
| FSM state | IDLE |
| count | 0 |
| running XOR | 0 |
| error bit | 0 |
| cfg_bus | all 0 (every matrix port undriven) |
| cfg_ready | 0 |
| cfg_busy | 0 |
| cfg_done | 0 |
| cfg_err | 0 |

REQ-031 rst asserted mid-load SHALL abort the load with no commit, and cfg_bus SHALL be 0 afterwards.
REQ-032 After rst deasserts, the first state change SHALL occur on the following rising clk edge.

Verification
REQ-033 Legal load: start, 18 words with word0=6'b001_010 (top0<-right1) and the rest 0, checksum 6'b001010 -> one cycle later cfg_bus[5:0]=6'b001010, all other bits 0, cfg_done=1 for one cycle.
REQ-034 Bad checksum: the same 18 words with checksum 6'b000000 -> cfg_err=1, cfg_bus unchanged from its prior value, no cfg_done.
REQ-035 Illegal word: word14 = 6'b100_010 (right index 4) with the correct XOR checksum -> cfg_err=1, no commit.
REQ-036 Backpressure: cfg_valid toggled randomly across a legal load -> same result as REQ-033, and exactly 19 handshakes counted.
REQ-037 Restart: cfg_start after 7 words, then a full legal load -> only the second load is committed; cfg_start coincident with a CHK handshake -> no commit and no error.
REQ-038 Reset mid-load: rst pulsed after 10 words -> all outputs 0 immediately without waiting for clk; a subsequent legal load commits normally.
